// File: rtl/ascii_decimal_accumulator.sv
// ascii_decimal_accumulator
//   Scans a stream of 64-bit ASCII words one byte per cycle (byte 0 = bits[7:0]),
//   folds decimal digits into a binary value and emits one number per
//   newline-terminated line. Numbers may span word boundaries.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_word/in_valid     input word and its valid
//   in_ready             word accepted on edge with in_valid & in_ready (combinational)
//   flush                end-of-input pulse: emit a pending number lacking a newline
//   num_out/num_valid    completed number, held until num_ready
//   num_ready            consumer handshake
//   num_count            numbers handed off since reset (wraps)
//   err_overflow         sticky: an accumulation exceeded VALUE_WIDTH bits
//   err_char             sticky: a byte other than digit, 0x0A or 0x00 was seen
module ascii_decimal_accumulator #(
  parameter int unsigned VALUE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            in_word,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [VALUE_WIDTH-1:0] num_out,
  output logic                   num_valid,
  input  logic                   num_ready,
  output logic [15:0]            num_count,
  output logic                   err_overflow,
  output logic                   err_char
);

  localparam int unsigned ExtW   = VALUE_WIDTH + 4;
  localparam int unsigned CountW = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [63:0]            word_q, word_d;
  logic [VALUE_WIDTH-1:0] acc_q, acc_d;
  logic                   seen_q, seen_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [VALUE_WIDTH-1:0] num_out_q, num_out_d;
  logic                   num_valid_q, num_valid_d;
  logic [CountW-1:0]      num_count_q, num_count_d;
  logic                   err_ovf_q, err_ovf_d;
  logic                   err_char_q, err_char_d;

  logic                   stall;
  logic                   accept;
  logic [7:0]             byte_cur;
  logic [ExtW-1:0]        acc_ext;

  // Current byte and the untruncated acc*10+digit; the extra 4 bits expose overflow.
  assign byte_cur = word_q[{idx_q, 3'b000} +: 8];
  assign acc_ext  = ExtW'(acc_q) * ExtW'(10) + ExtW'(byte_cur[3:0]);

  assign stall    = num_valid_q & ~num_ready;
  assign in_ready = ~rst & ~stall &
                    ((state_q == ST_IDLE) | ((state_q == ST_SCAN) & (idx_q == 3'd7)));
  assign accept   = in_valid & in_ready;

  // Next-state logic: handshake first, so an emit on the same edge reloads num_valid.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    acc_d        = acc_q;
    seen_d       = seen_q;
    flush_pend_d = flush_pend_q | flush;
    num_out_d    = num_out_q;
    num_valid_d  = num_valid_q;
    num_count_d  = num_count_q;
    err_ovf_d    = err_ovf_q;
    err_char_d   = err_char_q;

    if (num_valid_q && num_ready) begin
      num_valid_d = 1'b0;
      num_count_d = num_count_q + CountW'(1);
    end

    if (state_q == ST_SCAN) begin
      if (!stall) begin
        case (byte_cur) inside
          [8'h30:8'h39]: begin
            acc_d  = acc_ext[VALUE_WIDTH-1:0];
            seen_d = 1'b1;
            if (|acc_ext[ExtW-1:VALUE_WIDTH]) begin
              err_ovf_d = 1'b1;
            end
          end
          8'h0A: begin
            // Blank lines (no digits yet) produce nothing.
            if (seen_q) begin
              num_out_d   = acc_q;
              num_valid_d = 1'b1;
              acc_d       = '0;
              seen_d      = 1'b0;
            end
          end
          8'h00: begin
          end
          default: begin
            err_char_d = 1'b1;
          end
        endcase

        if (idx_q == 3'd7) begin
          if (accept) begin
            word_d  = in_word;
            idx_d   = 3'd0;
            state_d = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end else begin
      if (accept) begin
        word_d  = in_word;
        idx_d   = 3'd0;
        state_d = ST_SCAN;
      end else if (!stall && flush_pend_q) begin
        // Flush behaves like a newline on an idle scanner.
        flush_pend_d = flush;
        if (seen_q) begin
          num_out_d   = acc_q;
          num_valid_d = 1'b1;
          acc_d       = '0;
          seen_d      = 1'b0;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      word_q       <= '0;
      acc_q        <= '0;
      seen_q       <= 1'b0;
      flush_pend_q <= 1'b0;
      num_out_q    <= '0;
      num_valid_q  <= 1'b0;
      num_count_q  <= '0;
      err_ovf_q    <= 1'b0;
      err_char_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      acc_q        <= acc_d;
      seen_q       <= seen_d;
      flush_pend_q <= flush_pend_d;
      num_out_q    <= num_out_d;
      num_valid_q  <= num_valid_d;
      num_count_q  <= num_count_d;
      err_ovf_q    <= err_ovf_d;
      err_char_q   <= err_char_d;
    end
  end

  assign num_out      = num_out_q;
  assign num_valid    = num_valid_q;
  assign num_count    = num_count_q;
  assign err_overflow = err_ovf_q;
  assign err_char     = err_char_q;

endmodule

// File: tb/tb_ascii_decimal_accumulator.sv
// Testbench for ascii_decimal_accumulator: directed scenarios plus a randomized
// stream checked against a line-parsing reference model. A second instance with
// VALUE_WIDTH=8 shares all inputs and is used for the overflow scenario.
module tb_ascii_decimal_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        num_ready;
  logic        in_ready, in_ready8;
  logic [31:0] no32;
  logic        nv32, ovf32, chr32;
  logic [15:0] cnt32;
  logic [7:0]  no8;
  logic        nv8, ovf8, chr8;
  logic [15:0] cnt8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  bit ready_fix = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascii_decimal_accumulator #(.VALUE_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .num_out(no32), .num_valid(nv32), .num_ready(num_ready),
    .num_count(cnt32), .err_overflow(ovf32), .err_char(chr32));

  ascii_decimal_accumulator #(.VALUE_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready8),
    .flush(flush), .num_out(no8), .num_valid(nv8), .num_ready(num_ready),
    .num_count(cnt8), .err_overflow(ovf8), .err_char(chr8));

  // Single driver for num_ready: fixed level or random per cycle.
  always @(posedge clk) begin
    #1;
    num_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  // Record every handed-off number.
  logic [31:0] got[$];
  logic [7:0]  got8[$];
  always @(negedge clk) begin
    if (!rst && num_ready) begin
      if (nv32) got.push_back(no32);
      if (nv8)  got8.push_back(no8);
    end
  end

  // Reference model: parse the byte stream line by line.
  logic [31:0]     exp_q[$];
  longint unsigned m_acc;
  bit              m_seen, m_ovf, m_char;
  int              m_cnt;

  function automatic void model_reset();
    m_acc = 0; m_seen = 0; m_ovf = 0; m_char = 0; m_cnt = 0;
  endfunction

  function automatic void model_emit();
    if (m_seen) begin
      exp_q.push_back(32'(m_acc));
      m_acc = 0;
      m_seen = 0;
      m_cnt++;
    end
  endfunction

  function automatic void model_word(input logic [63:0] w);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = w[8*i +: 8];
      if (b >= 8'h30 && b <= 8'h39) begin
        m_acc = m_acc * 10 + (64'(b) - 64'd48);
        if (m_acc >= 64'h1_0000_0000) begin
          m_ovf = 1;
          m_acc = m_acc % 64'h1_0000_0000;
        end
        m_seen = 1;
      end else if (b == 8'h0A) begin
        model_emit();
      end else if (b != 8'h00) begin
        m_char = 1;
      end
    end
  endfunction

  task automatic send_word(input logic [63:0] w, output int acc_cyc);
    bit done = 0;
    int n = 0;
    in_word = w;
    in_valid = 1'b1;
    while (!done && n < 400) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
      n++;
    end
    in_valid = 1'b0;
    acc_cyc = cyc;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL send_word_timeout word=%h accepted=%0d required=1", w, done);
    end else begin
      model_word(w);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_emit();
  endtask

  // Wait until the scanner is idle and unstalled with no word offered.
  task automatic wait_idle();
    int n = 0;
    int run = 0;
    while (run < 2 && n < 500) begin
      @(negedge clk);
      if (in_ready) run++; else run = 0;
      n++;
    end
    @(posedge clk);
    #1;
    tests++;
    if (run < 2) begin
      fails++;
      $display("FAIL wait_idle_timeout idle_run=%0d required=2", run);
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    ready_fix = 1'b1;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic settle_ready();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_ready got=%b required=0", in_ready);
    end
    in_valid = 1'b0;
    do_reset();
    tests++;
    if (nv32 !== 1'b0 || no32 !== 32'd0 || cnt32 !== 16'd0 || ovf32 !== 1'b0 || chr32 !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b out=%0d cnt=%0d ovf=%b chr=%b required all 0",
               nv32, no32, cnt32, ovf32, chr32);
    end
  endtask

  task automatic test_single();
    int a;
    int gb;
    ready_fix = 1'b1;
    settle_ready();
    gb = got.size();
    send_word(64'h0000_0000_000A_3231, a);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (nv32 !== 1'b0) begin
      fails++;
      $display("FAIL single_early_valid got=%b required=0", nv32);
    end
    @(posedge clk);
    #1;
    tests++;
    if (nv32 !== 1'b1 || no32 !== 32'd12) begin
      fails++;
      $display("FAIL single_emit got v=%b out=%0d required v=1 out=12", nv32, no32);
    end
    drain();
    tests++;
    if (cnt32 !== 16'd1 || got.size() - gb != 1) begin
      fails++;
      $display("FAIL single_count got cnt=%0d emits=%0d required 1 1", cnt32, got.size() - gb);
    end
  endtask

  task automatic test_spanning();
    int a;
    int gb = got.size();
    send_word(64'h0000_0000_3936_3931, a);
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (got.size() != gb || nv32 !== 1'b0) begin
      fails++;
      $display("FAIL span_no_early_emit got emits=%0d v=%b required 0 0", got.size() - gb, nv32);
    end
    send_word(64'h0000_0000_0000_000A, a);
    drain();
    tests++;
    if (got.size() - gb != 1) begin
      fails++;
      $display("FAIL span_emit_count got=%0d required=1", got.size() - gb);
    end else if (got[gb] !== 32'd1969) begin
      fails++;
      $display("FAIL span_value got=%0d required=1969", got[gb]);
    end
  endtask

  task automatic test_two_per_word();
    int a;
    int gb = got.size();
    send_word(64'h0A39_3639_310A_3431, a);
    drain();
    tests++;
    if (got.size() - gb != 2) begin
      fails++;
      $display("FAIL two_count got=%0d required=2", got.size() - gb);
    end else if (got[gb] !== 32'd14 || got[gb+1] !== 32'd1969) begin
      fails++;
      $display("FAIL two_values got=%0d,%0d required=14,1969", got[gb], got[gb+1]);
    end
    tests++;
    if (cnt32 !== 16'(m_cnt)) begin
      fails++;
      $display("FAIL two_num_count got=%0d required=%0d", cnt32, 16'(m_cnt));
    end
  endtask

  task automatic test_backpressure();
    int a;
    int gb;
    int n = 0;
    ready_fix = 1'b0;
    settle_ready();
    gb = got.size();
    send_word(64'h0A39_3639_310A_3431, a);
    while (nv32 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (nv32 !== 1'b1) begin
      fails++;
      $display("FAIL bp_first_emit_timeout got v=%b required=1", nv32);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (nv32 !== 1'b1 || no32 !== 32'd14 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold cycle=%0d got v=%b out=%0d in_ready=%b required 1 14 0",
                 k, nv32, no32, in_ready);
      end
    end
    drain();
    tests++;
    if (got.size() - gb != 2) begin
      fails++;
      $display("FAIL bp_count got=%0d required=2", got.size() - gb);
    end else if (got[gb] !== 32'd14 || got[gb+1] !== 32'd1969) begin
      fails++;
      $display("FAIL bp_values got=%0d,%0d required=14,1969", got[gb], got[gb+1]);
    end
  endtask

  task automatic test_overflow();
    int a;
    int gb;
    int gb8;
    do_reset();
    gb = got.size();
    gb8 = got8.size();
    send_word(64'h0000_0000_0A30_3033, a);
    drain();
    tests++;
    if (got8.size() - gb8 != 1) begin
      fails++;
      $display("FAIL ovf_count8 got=%0d required=1", got8.size() - gb8);
    end else if (got8[gb8] !== 8'd44) begin
      fails++;
      $display("FAIL ovf_value8 got=%0d required=44", got8[gb8]);
    end
    tests++;
    if (ovf8 !== 1'b1 || chr8 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_flags8 got ovf=%b chr=%b required 1 0", ovf8, chr8);
    end
    tests++;
    if (got.size() - gb != 1 || ovf32 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_wide got emits=%0d ovf=%b required 1 0", got.size() - gb, ovf32);
    end else if (got[gb] !== 32'd300) begin
      fails++;
      $display("FAIL ovf_wide_value got=%0d required=300", got[gb]);
    end
  endtask

  task automatic test_flush_reset();
    int a;
    int gb;
    do_reset();
    gb = got.size();
    send_word(64'h0000_0000_0030_3031, a);
    pulse_flush();
    drain();
    tests++;
    if (got.size() - gb != 1) begin
      fails++;
      $display("FAIL flush_count got=%0d required=1", got.size() - gb);
    end else if (got[gb] !== 32'd100) begin
      fails++;
      $display("FAIL flush_value got=%0d required=100", got[gb]);
    end
    // Reset in the middle of "55".
    send_word(64'h0000_0000_0000_3535, a);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL midreset_in_ready got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tests++;
    if (nv32 !== 1'b0 || no32 !== 32'd0 || cnt32 !== 16'd0 || ovf32 !== 1'b0 || chr32 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs got v=%b out=%0d cnt=%0d ovf=%b chr=%b required all 0",
               nv32, no32, cnt32, ovf32, chr32);
    end
    gb = got.size();
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (got.size() != gb || nv32 !== 1'b0) begin
      fails++;
      $display("FAIL midreset_no_emit got emits=%0d required=0", got.size() - gb);
    end
    send_word(64'h0000_0000_0000_0A37, a);
    drain();
    tests++;
    if (got.size() - gb != 1 || cnt32 !== 16'd1) begin
      fails++;
      $display("FAIL after_reset_count got emits=%0d cnt=%0d required 1 1", got.size() - gb, cnt32);
    end else if (got[gb] !== 32'd7) begin
      fails++;
      $display("FAIL after_reset_value got=%0d required=7", got[gb]);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    int gb;
    ready_fix = 1'b1;
    settle_ready();
    gb = got.size();
    send_word(64'h0000_0000_0000_0A31, a0);
    send_word(64'h0A33_3200_0000_0000, a1);
    send_word(64'h0000_0000_0000_0A34, a2);
    tests++;
    if (a1 - a0 != 8 || a2 - a1 != 8) begin
      fails++;
      $display("FAIL b2b_spacing got=%0d,%0d required=8,8", a1 - a0, a2 - a1);
    end
    drain();
    tests++;
    if (got.size() - gb != 3) begin
      fails++;
      $display("FAIL b2b_count got=%0d required=3", got.size() - gb);
    end else if (got[gb] !== 32'd1 || got[gb+1] !== 32'd23 || got[gb+2] !== 32'd4) begin
      fails++;
      $display("FAIL b2b_values got=%0d,%0d,%0d required=1,23,4", got[gb], got[gb+1], got[gb+2]);
    end
  endtask

  task automatic test_random();
    int a;
    int gb;
    int eb;
    logic [63:0] w;
    int r;
    do_reset();
    gb = got.size();
    eb = exp_q.size();
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 15);
        if (r <= 9)       w[8*i +: 8] = 8'h30 + 8'(r);
        else if (r <= 11) w[8*i +: 8] = 8'h0A;
        else if (r == 12) w[8*i +: 8] = 8'h00;
        else if (r == 13) w[8*i +: 8] = 8'h41;
        else              w[8*i +: 8] = 8'h35;
      end
      send_word(w, a);
      if ($urandom_range(0, 7) == 0) begin
        pulse_flush();
        wait_idle();
      end
    end
    drain();
    tests++;
    if (got.size() - gb != exp_q.size() - eb) begin
      fails++;
      $display("FAIL rand_count got=%0d required=%0d", got.size() - gb, exp_q.size() - eb);
    end else begin
      for (int i = 0; i < exp_q.size() - eb; i++) begin
        tests++;
        if (got[gb+i] !== exp_q[eb+i]) begin
          fails++;
          $display("FAIL rand_value idx=%0d got=%0d required=%0d", i, got[gb+i], exp_q[eb+i]);
        end
      end
    end
    tests++;
    if (cnt32 !== 16'(m_cnt) || ovf32 !== m_ovf || chr32 !== m_char) begin
      fails++;
      $display("FAIL rand_status got cnt=%0d ovf=%b chr=%b required cnt=%0d ovf=%b chr=%b",
               cnt32, ovf32, chr32, 16'(m_cnt), m_ovf, m_char);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_spanning();
    test_two_per_word();
    test_backpressure();
    test_overflow();
    test_flush_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete required=finish");
    $fatal(1);
  end

endmodule
